// File: rtl/cpu_trace_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_trace_pkg
// Shared types for the CPU retirement-trace monitor.
//   trace_kind_e  : record kind encoding (REG/LOAD/STORE/HALT)
//   trace_state_e : monitor sequencing state (IDLE/RUN/DRAIN/DONE)
//   trace_rec_t   : trace record layout at the default widths; the monitor
//                   builds the same layout from its own width parameters.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a per-record cycle stamp.
// ---------------------------------------------------------------------------
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } trace_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int TRACE_DATA_W = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TRACE_CNT_W  = 32;
`endif

  typedef struct packed {
    trace_kind_e             kind;
    logic [TRACE_DATA_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
    logic [TRACE_CNT_W-1:0]  cycle;
`endif
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor_if
// Bundles the CPU commit signals sampled by the monitor and the record
// drain channel (valid/ready).
//   master : the CPU/consumer side (drives commit signals and rec_ready)
//   slave  : the monitor side (samples commit signals, drives rec_*)
// Optional feature macro: TRACE_TIMESTAMP_EN adds rec_cycle (CNT_W bits).
// ---------------------------------------------------------------------------
interface cpu_trace_monitor_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
`ifdef TRACE_TIMESTAMP_EN
  ,
  parameter int CNT_W  = 32
`endif
);

  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_reg_sel;
  logic [DATA_W-1:0] wb_reg_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              hlt;

  logic              rec_valid;
  logic              rec_ready;
  logic [1:0]        rec_kind;
  logic [DATA_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_data;
`ifdef TRACE_TIMESTAMP_EN
  logic [CNT_W-1:0]  rec_cycle;
`endif

  modport master (
    output wb_reg_write, wb_reg_sel, wb_reg_data,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, hlt,
    output rec_ready,
`ifdef TRACE_TIMESTAMP_EN
    input  rec_cycle,
`endif
    input  rec_valid, rec_kind, rec_addr, rec_data
  );

  modport slave (
    input  wb_reg_write, wb_reg_sel, wb_reg_data,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, hlt,
    input  rec_ready,
`ifdef TRACE_TIMESTAMP_EN
    output rec_cycle,
`endif
    output rec_valid, rec_kind, rec_addr, rec_data
  );

endinterface

// File: rtl/cpu_trace_monitor_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo_mpush
// Record FIFO accepting 0..4 in-order pushes and at most one pop per cycle.
// The caller guarantees push_cnt_i never exceeds free_o.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset (pointers/occupancy)
//   push_cnt_i    : number of valid entries in push_rec_i (0..4, slot 0 first)
//   push_rec_i    : up to four records, packed in push order
//   pop_i         : consume the head record (ignored when empty)
//   head_o        : record at the read pointer
//   valid_o       : FIFO non-empty
//   occ_o, free_o : occupancy and free entries at the start of the cycle
// ---------------------------------------------------------------------------
module trace_fifo_mpush #(
  parameter int REC_W      = 34,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            push_cnt_i,
  input  logic [3:0][REC_W-1:0] push_rec_i,
  input  logic                  pop_i,
  output logic [REC_W-1:0]      head_o,
  output logic                  valid_o,
  output logic [AW:0]           occ_o,
  output logic [AW:0]           free_o
);

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             pop_eff;

  assign pop_eff = pop_i && (occ_q != '0);
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;
  assign free_o  = (AW+1)'(FIFO_DEPTH) - occ_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_eff);
      occ_q    <= occ_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_eff);
    end
  end

  // Storage is not reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < push_cnt_i) begin
        mem_q[wr_ptr_q + AW'(i)] <= push_rec_i[i];
      end
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// ---------------------------------------------------------------------------
// cpu_trace_monitor
// Retirement-trace monitor: samples writeback/memory commit signals, counts
// cycles and retired instructions, and packs REG/LOAD/STORE/HALT events into
// records pushed to a multi-push FIFO drained over a valid/ready channel.
// Sequencing IDLE -> RUN -> DRAIN -> DONE with a cycle watchdog.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   run            : start capture (sampled in IDLE)
//   bus            : commit signals in, record channel out (slave modport)
//   cycle_count, inst_count, drop_count : saturating statistics
//   state          : IDLE 0, RUN 1, DRAIN 2, DONE 3
//   halted, timeout, overflow : sticky status
// Optional feature macro: TRACE_TIMESTAMP_EN stamps each record with the
// cycle_count value of its capture cycle (bus.rec_cycle).
// ---------------------------------------------------------------------------
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  cpu_trace_monitor_if.slave   bus,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     inst_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic [1:0]           state,
  output logic                 halted,
  output logic                 timeout,
  output logic                 overflow
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  // Same layout as trace_rec_t, sized by this instance's parameters.
  typedef struct packed {
    trace_kind_e       kind;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
    logic [CNT_W-1:0]  cycle;
`endif
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  function automatic rec_t mk_rec(input trace_kind_e       k,
                                  input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] d);
    rec_t r;
    r      = '0;
    r.kind = k;
    r.addr = a;
    r.data = d;
    return r;
  endfunction

  trace_state_e     state_q;
  logic [CNT_W-1:0] cycle_count_q, inst_count_q, drop_count_q;
  logic             halted_q, timeout_q, overflow_q;

  logic             in_run;
  logic [2:0]       n_data, need, n_drop, push_cnt;
  logic             data_ok, halt_ok, halt_lost, is_inst, limit_hit, pop;
  logic [FW-1:0]    occ, free;
  logic [CNT_W-1:0] cycle_inc;
  rec_t [3:0]       push_rec;
  logic [REC_W-1:0] head_raw;
  rec_t             head;
  logic             fifo_valid;

  assign in_run    = (state_q == ST_RUN);
  assign n_data    = {2'b0, bus.wb_reg_write} + {2'b0, bus.mem_read} + {2'b0, bus.mem_write};
  assign need      = n_data + {2'b0, bus.hlt};
  // A pending HALT reserves a slot, so data events must fit alongside it.
  assign data_ok   = (FW'(need) <= free);
  assign halt_ok   = bus.hlt && (free != '0);
  assign n_drop    = (in_run && !data_ok) ? n_data : 3'd0;
  assign halt_lost = in_run && bus.hlt && (free == '0);
  assign is_inst   = bus.hlt || bus.wb_reg_write || bus.mem_write;
  assign cycle_inc = sat_add(cycle_count_q, 3'd1);
  assign limit_hit = (cycle_inc == CNT_W'(CYCLE_LIMIT));

  // Compact the accepted events into consecutive push slots in fixed order.
  always_comb begin
    push_rec = '0;
    push_cnt = '0;
    if (in_run && data_ok) begin
      if (bus.wb_reg_write) begin
        push_rec[push_cnt[1:0]] = mk_rec(KIND_REG, DATA_W'(bus.wb_reg_sel), bus.wb_reg_data);
        push_cnt = push_cnt + 3'd1;
      end
      if (bus.mem_read) begin
        push_rec[push_cnt[1:0]] = mk_rec(KIND_LOAD, bus.mem_addr, bus.mem_rdata);
        push_cnt = push_cnt + 3'd1;
      end
      if (bus.mem_write) begin
        push_rec[push_cnt[1:0]] = mk_rec(KIND_STORE, bus.mem_addr, bus.mem_wdata);
        push_cnt = push_cnt + 3'd1;
      end
    end
    if (in_run && halt_ok) begin
      push_rec[push_cnt[1:0]] = mk_rec(KIND_HALT, '0, '0);
      push_cnt = push_cnt + 3'd1;
    end
`ifdef TRACE_TIMESTAMP_EN
    for (int i = 0; i < 4; i++) begin
      push_rec[i].cycle = cycle_count_q;
    end
`endif
  end

  assign pop = fifo_valid && bus.rec_ready;

  trace_fifo_mpush #(
    .REC_W      (REC_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_cnt_i (push_cnt),
    .push_rec_i (push_rec),
    .pop_i      (pop),
    .head_o     (head_raw),
    .valid_o    (fifo_valid),
    .occ_o      (occ),
    .free_o     (free)
  );

  assign head          = rec_t'(head_raw);
  assign bus.rec_valid = fifo_valid;
  assign bus.rec_kind  = head.kind;
  assign bus.rec_addr  = head.addr;
  assign bus.rec_data  = head.data;
`ifdef TRACE_TIMESTAMP_EN
  assign bus.rec_cycle = head.cycle;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      inst_count_q  <= '0;
      drop_count_q  <= '0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_RUN;
        end
        ST_RUN: begin
          cycle_count_q <= cycle_inc;
          if (is_inst) inst_count_q <= sat_add(inst_count_q, 3'd1);
          if ((n_drop != 3'd0) || halt_lost) begin
            drop_count_q <= sat_add(drop_count_q, n_drop + {2'b0, halt_lost});
            overflow_q   <= 1'b1;
          end
          // Halt takes precedence over the watchdog in the same cycle.
          if (bus.hlt) begin
            state_q  <= ST_DRAIN;
            halted_q <= 1'b1;
          end else if (limit_hit) begin
            state_q   <= ST_DRAIN;
            timeout_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (occ == '0) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cycle_count = cycle_count_q;
  assign inst_count  = inst_count_q;
  assign drop_count  = drop_count_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

endmodule
